// File: rtl/temp_bcd_converter.sv
`default_nettype none
// ============================================================================
// Module   : temp_bcd_converter
// Function : Clamped binary temperature to three BCD digits (double dabble),
//            optionally held back until the next video frame start.
// Revision : 1.0
// ============================================================================
module temp_bcd_converter #(
    parameter int          IN_WIDTH   = 10,
    parameter int unsigned FRAME_SYNC = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [IN_WIDTH-1:0] temp_raw,
    input  logic                temp_valid,
    input  logic                frame_start,
    output logic                busy,
    output logic [3:0]          temp_value_100,
    output logic [3:0]          temp_value_10,
    output logic [3:0]          temp_value_1,
    output logic                overflow,
    output logic                done
);

    localparam logic [9:0] c_MAX_VALUE = 10'd999;
    localparam logic [3:0] c_LAST_ITER = 4'(IN_WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_LOAD  = 2'd2
    } state_t;

    state_t                r_state;
    logic [IN_WIDTH-1:0]   r_bin;
    logic [11:0]           r_bcd;
    logic [3:0]            r_cnt;
    logic                  r_ovf_next;

    logic [9:0]            w_raw_ext;
    logic [9:0]            w_clamped;
    logic                  w_ovf;
    logic [11:0]           w_bcd_adj;
    logic                  w_load_go;

    function automatic logic [3:0] add3(input logic [3:0] nib);
        return (nib >= 4'd5) ? nib + 4'd3 : nib;
    endfunction

    // Clamp is done at 10 bits so narrower inputs can never trip it.
    assign w_raw_ext = 10'(temp_raw);
    assign w_ovf     = (w_raw_ext > c_MAX_VALUE);
    assign w_clamped = w_ovf ? c_MAX_VALUE : w_raw_ext;

    assign w_bcd_adj = {add3(r_bcd[11:8]), add3(r_bcd[7:4]), add3(r_bcd[3:0])};
    assign w_load_go = (FRAME_SYNC == 0) || frame_start;

    assign busy = (r_state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_bin          <= '0;
            r_bcd          <= '0;
            r_cnt          <= '0;
            r_ovf_next     <= 1'b0;
            temp_value_100 <= 4'd0;
            temp_value_10  <= 4'd0;
            temp_value_1   <= 4'd0;
            overflow       <= 1'b0;
            done           <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (temp_valid) begin
                        r_bin      <= w_clamped[IN_WIDTH-1:0];
                        r_ovf_next <= w_ovf;
                        r_bcd      <= '0;
                        r_cnt      <= '0;
                        r_state    <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_bcd <= {w_bcd_adj[10:0], r_bin[IN_WIDTH-1]};
                    r_bin <= {r_bin[IN_WIDTH-2:0], 1'b0};
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt == c_LAST_ITER) begin
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    // All digits and the flag move together so the renderer never sees a mix.
                    if (w_load_go) begin
                        temp_value_100 <= r_bcd[11:8];
                        temp_value_10  <= r_bcd[7:4];
                        temp_value_1   <= r_bcd[3:0];
                        overflow       <= r_ovf_next;
                        done           <= 1'b1;
                        r_state        <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_temp_bcd_converter.sv
`default_nettype none
// ============================================================================
// Module   : tb_temp_bcd_converter
// Function : Scoreboard bench for temp_bcd_converter (immediate and frame-synced).
// Revision : 1.0
// ============================================================================
module tb_temp_bcd_converter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] raw0, raw1;
    logic       v0, v1, fs0, fs1;
    logic       busy0, ov0, d0, busy1, ov1, d1;
    logic [3:0] h0, t0, o0, h1, t1, o1;

    always #5 clk = ~clk;

    temp_bcd_converter #(.IN_WIDTH(10), .FRAME_SYNC(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .temp_raw(raw0), .temp_valid(v0),
        .frame_start(fs0), .busy(busy0), .temp_value_100(h0),
        .temp_value_10(t0), .temp_value_1(o0), .overflow(ov0), .done(d0)
    );

    temp_bcd_converter #(.IN_WIDTH(10), .FRAME_SYNC(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .temp_raw(raw1), .temp_valid(v1),
        .frame_start(fs1), .busy(busy1), .temp_value_100(h1),
        .temp_value_10(t1), .temp_value_1(o1), .overflow(ov1), .done(d1)
    );

    typedef struct {
        logic [3:0] h;
        logic [3:0] t;
        logic [3:0] o;
        logic       ov;
        int         at;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Monitor: pops on every done, otherwise the display must hold its last value.
    initial begin
        logic [12:0] sh0;
        logic [12:0] sh1;
        exp_t        e;
        sh0 = '0;
        sh1 = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                q0.delete();
                q1.delete();
                sh0 = '0;
                sh1 = '0;
                chk("rst_outputs0", 32'({d0, busy0, ov0, h0, t0, o0}), 32'd0);
                chk("rst_outputs1", 32'({d1, busy1, ov1, h1, t1, o1}), 32'd0);
            end else begin
                if (d0) begin
                    if (q0.size() == 0) begin
                        chk("unexpected_done0", 32'(d0), 32'd0);
                    end else begin
                        e = q0.pop_front();
                        chk("result0", 32'({ov0, h0, t0, o0}), 32'({e.ov, e.h, e.t, e.o}));
                        if (e.at >= 0) chk("latency0", 32'(cyc), 32'(e.at));
                        sh0 = {e.ov, e.h, e.t, e.o};
                    end
                end else begin
                    chk("hold0", 32'({ov0, h0, t0, o0}), 32'(sh0));
                end
                if (d1) begin
                    if (q1.size() == 0) begin
                        chk("unexpected_done1", 32'(d1), 32'd0);
                    end else begin
                        e = q1.pop_front();
                        chk("result1", 32'({ov1, h1, t1, o1}), 32'({e.ov, e.h, e.t, e.o}));
                        sh1 = {e.ov, e.h, e.t, e.o};
                    end
                end else begin
                    chk("hold1", 32'({ov1, h1, t1, o1}), 32'(sh1));
                end
            end
        end
    end

    task automatic send0(input logic [9:0] raw, input logic [3:0] h, input logic [3:0] t,
                         input logic [3:0] o, input logic ov, output int cap);
        exp_t e;
        @(negedge clk);
        raw0 = raw;
        v0   = 1'b1;
        cap  = cyc + 1;
        e    = '{h, t, o, ov, cap + 11};
        q0.push_back(e);
        @(negedge clk);
        v0 = 1'b0;
    endtask

    task automatic send1(input logic [9:0] raw, input logic [3:0] h, input logic [3:0] t,
                         input logic [3:0] o, input logic ov);
        exp_t e;
        @(negedge clk);
        raw1 = raw;
        v1   = 1'b1;
        e    = '{h, t, o, ov, -1};
        q1.push_back(e);
        @(negedge clk);
        v1 = 1'b0;
    endtask

    task automatic wait_idle0();
        int n;
        n = 0;
        while (busy0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy0) chk("idle_timeout0", 32'(busy0), 32'd0);
    endtask

    task automatic pulse_fs1();
        @(negedge clk);
        fs1 = 1'b1;
        @(negedge clk);
        fs1 = 1'b0;
    endtask

    initial begin
        int cap;
        int n;
        int v;
        rst_n = 1'b0;
        raw0 = '0; raw1 = '0;
        v0 = 1'b0; v1 = 1'b0; fs0 = 1'b0; fs1 = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_state0", 32'({busy0, d0, ov0, h0, t0, o0}), 32'd0);
        chk("reset_state1", 32'({busy1, d1, ov1, h1, t1, o1}), 32'd0);
        rst_n = 1'b1;

        // 255: digits, latency, busy window length
        send0(10'd255, 4'd2, 4'd5, 4'd5, 1'b0, cap);
        n = 0;
        while (busy0 && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk("busy_cycles", 32'(n), 32'd11);

        send0(10'd1023, 4'd9, 4'd9, 4'd9, 1'b1, cap);
        wait_idle0();
        send0(10'd0, 4'd0, 4'd0, 4'd0, 1'b0, cap);
        wait_idle0();

        // Second request mid-conversion must be dropped
        send0(10'd72, 4'd0, 4'd7, 4'd2, 1'b0, cap);
        repeat (3) @(negedge clk);
        raw0 = 10'd999;
        v0   = 1'b1;
        @(negedge clk);
        v0 = 1'b0;
        wait_idle0();
        chk("busy_fall_cycle", 32'(cyc), 32'(cap + 11));
        repeat (14) @(negedge clk);

        // Request landing exactly on the load edge must be dropped
        send0(10'd100, 4'd1, 4'd0, 4'd0, 1'b0, cap);
        repeat (10) @(negedge clk);
        raw0 = 10'd500;
        v0   = 1'b1;
        @(negedge clk);
        v0 = 1'b0;
        wait_idle0();
        repeat (14) @(negedge clk);
        chk("load_edge_ignored", 32'(busy0), 32'd0);

        for (int i = 0; i < 1024; i++) begin
            v = (i > 999) ? 999 : i;
            send0(10'(i), 4'(v / 100), 4'((v / 10) % 10), 4'(v % 10), (i > 999), cap);
            wait_idle0();
        end

        // Frame-synced instance
        send1(10'd321, 4'd3, 4'd2, 4'd1, 1'b0);
        repeat (2) @(negedge clk);
        pulse_fs1();
        repeat (12) @(negedge clk);
        chk("fs_wait_busy_a", 32'(busy1), 32'd1);
        @(negedge clk);
        fs1 = 1'b1;
        @(negedge clk);
        fs1 = 1'b0;
        chk("fs_done_a", 32'(d1), 32'd1);
        chk("fs_idle_a", 32'(busy1), 32'd0);
        pulse_fs1();
        repeat (3) @(negedge clk);

        send1(10'd105, 4'd1, 4'd0, 4'd5, 1'b0);
        repeat (40) @(negedge clk);
        chk("fs_wait_busy_b", 32'(busy1), 32'd1);
        chk("fs_hold_b", 32'({h1, t1, o1}), 32'h321);
        @(negedge clk);
        fs1 = 1'b1;
        @(negedge clk);
        fs1 = 1'b0;
        chk("fs_done_b", 32'(d1), 32'd1);
        @(negedge clk);
        chk("fs_done_width", 32'(d1), 32'd0);

        // Reset during SHIFT iteration 6 of 888
        send0(10'd888, 4'd8, 4'd8, 4'd8, 1'b0, cap);
        repeat (5) @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_clear", 32'({busy0, ov0, h0, t0, o0}), 32'd0);
        @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        raw0  = 10'd42;
        v0    = 1'b1;
        q0.push_back('{4'd0, 4'd4, 4'd2, 1'b0, cyc + 12});
        @(posedge clk);
        @(negedge clk);
        v0 = 1'b0;
        chk("accept_after_rst", 32'(busy0), 32'd1);
        wait_idle0();

        repeat (5) @(negedge clk);
        chk("q0_drained", 32'(q0.size()), 32'd0);
        chk("q1_drained", 32'(q1.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
